// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants ALU/MDU results into a small in-order write queue
// that drains into a single register-file write port.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dst,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dst,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        wr_stall,
    output logic        wr_en,
    output logic [4:0]  wr_dst,
    output logic [31:0] wr_data,
    output logic [31:0] pending_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    dst_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;

    logic        space;
    logic        alu_acc, mdu_acc;
    logic        push, pop;
    logic [4:0]  push_dst;
    logic [31:0] push_data;

    // Readies are forced low during reset so nothing is granted while rst_n is low.
    always_comb begin
        space     = rst_n && (count_q < DEPTH_C);
        mdu_ready = space && mdu_valid && (!alu_valid || (starve_q == LIMIT_C));
        alu_ready = space && !mdu_ready;
    end

    always_comb begin
        alu_acc   = alu_valid && alu_ready;
        mdu_acc   = mdu_valid && mdu_ready;
        push_dst  = mdu_acc ? mdu_dst  : alu_dst;
        push_data = mdu_acc ? mdu_data : alu_data;
        push      = (alu_acc || mdu_acc) && (push_dst != 5'd0);
        pop       = (count_q != '0) && !wr_stall;
    end

    always_comb begin
        wr_en   = pop;
        wr_dst  = '0;
        wr_data = '0;
        if (count_q != '0) begin
            wr_dst  = dst_q[rd_ptr_q];
            wr_data = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pending_mask[dst_q[i]] = 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts cycles the MDU waits behind an ALU grant.
    always_comb begin
        starve_d = starve_q;
        if (mdu_acc || !mdu_valid) begin
            starve_d = '0;
        end else if (alu_acc && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            if (pop) vld_q[rd_ptr_q] <= 1'b0;
            if (push) begin
                vld_q[wr_ptr_q]  <= 1'b1;
                dst_q[wr_ptr_q]  <= push_dst;
                data_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule
